// File: rtl/kuuga_sc_mem_responder_if.sv
// Request/grant/response bundle between the simple cache master port and the memory responder.
// Signal names keep the responder-side direction suffixes so both ends read the same.
interface kuuga_sc_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  we_i;
  logic [3:0]            be_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;
  logic                  busy_o;

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, busy_o
  );
endinterface

// File: rtl/kuuga_sc_mem_responder.sv
// Word-addressed RAM responder for the cache req/gnt/rvalid port with programmable grant/response delay.
// Optional KUUGA_SC_RESP_STATS_EN adds saturating read/write/error response counters.
module kuuga_sc_mem_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int GNT_DELAY       = 2,
  parameter int RVALID_DELAY    = 3
) (
  input  logic clk,
  input  logic rst,
`ifdef KUUGA_SC_RESP_STATS_EN
  output logic [31:0] rd_count_o,
  output logic [31:0] wr_count_o,
  output logic [31:0] err_count_o,
`endif
  kuuga_sc_mem_responder_if.slave mem_if
);

  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    GNT_WAIT,
    GRANT,
    RESP_WAIT,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  we_q;
  logic                  oor_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  logic [IDX_W-1:0]      in_idx;
  logic                  in_oor;
  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_we;
  logic                  cur_oor;

  assign in_idx = mem_if.addr_i[IDX_W+1:2];
  assign in_oor = (mem_if.addr_i >> (IDX_W + 2)) != '0;

  // With RVALID_DELAY=0 the RESP entry edge is the GRANT edge, before the latches update.
  assign cur_idx = (state_q == GRANT) ? in_idx      : idx_q;
  assign cur_we  = (state_q == GRANT) ? mem_if.we_i : we_q;
  assign cur_oor = (state_q == GRANT) ? in_oor      : oor_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_if.req_i) begin
          if (GNT_DELAY == 0) begin
            state_d = GRANT;
          end else begin
            state_d = GNT_WAIT;
            cnt_d   = 4'(GNT_DELAY);
          end
        end
      end
      GNT_WAIT: begin
        if (!mem_if.req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d = GRANT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GRANT: begin
        if (RVALID_DELAY == 0) begin
          state_d = RESP;
        end else begin
          state_d = RESP_WAIT;
          cnt_d   = 4'(RVALID_DELAY);
        end
      end
      RESP_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == GRANT) begin
        idx_q <= in_idx;
        we_q  <= mem_if.we_i;
        oor_q <= in_oor;
      end
      if (state_d == RESP) begin
        rdata_q <= (cur_we || cur_oor) ? '0 : mem[cur_idx];
        err_q   <= cur_oor;
      end else begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // RAM has no reset; a reset on the grant edge itself suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == GRANT && mem_if.we_i && !in_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_if.be_i[b]) begin
          mem[in_idx][8*b +: 8] <= mem_if.wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign mem_if.gnt_o    = (state_q == GRANT);
  assign mem_if.rvalid_o = (state_q == RESP);
  assign mem_if.rdata_o  = rdata_q;
  assign mem_if.err_o    = err_q;
  assign mem_if.busy_o   = (state_q != IDLE);

`ifdef KUUGA_SC_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_o  <= '0;
      wr_count_o  <= '0;
      err_count_o <= '0;
    end else if (state_q == RESP) begin
      if (!we_q && rd_count_o != 32'hFFFF_FFFF) rd_count_o <= rd_count_o + 32'd1;
      if (we_q && wr_count_o != 32'hFFFF_FFFF) wr_count_o <= wr_count_o + 32'd1;
      if (err_q && err_count_o != 32'hFFFF_FFFF) err_count_o <= err_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kuuga_sc_mem_responder.sv
// Randomised scoreboard bench for kuuga_sc_mem_responder (default delays plus a zero-delay instance).
module tb_kuuga_sc_mem_responder;

  localparam int GA = 2;
  localparam int RA = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kuuga_sc_mem_responder_if ia ();
  kuuga_sc_mem_responder_if ib ();

`ifdef KUUGA_SC_RESP_STATS_EN
  logic [31:0] a_rd, a_wr, a_er, b_rd, b_wr, b_er;
`endif

  kuuga_sc_mem_responder #(.GNT_DELAY(GA), .RVALID_DELAY(RA)) dut_a (
    .clk(clk),
    .rst(rst),
`ifdef KUUGA_SC_RESP_STATS_EN
    .rd_count_o(a_rd),
    .wr_count_o(a_wr),
    .err_count_o(a_er),
`endif
    .mem_if(ia)
  );

  kuuga_sc_mem_responder #(.GNT_DELAY(0), .RVALID_DELAY(0)) dut_b (
    .clk(clk),
    .rst(rst),
`ifdef KUUGA_SC_RESP_STATS_EN
    .rd_count_o(b_rd),
    .wr_count_o(b_wr),
    .err_count_o(b_er),
`endif
    .mem_if(ib)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mm [32];
  int          n_chk = 0;
  int          n_fail = 0;
  int          m_rd = 0, m_wr = 0, m_err = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: RAM is 4 KiB of bytes, only the first 32 words are ever touched in range.
  task automatic model(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output exp_t e);
    int unsigned widx;
    logic [31:0] mask;
    widx = addr / 4;
    mask = 0;
    for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
    e.rdata = 0;
    e.err   = (addr >= 32'h1000);
    if (!e.err) begin
      if (we) mm[widx] = (mm[widx] & ~mask) | (wd & mask);
      else    e.rdata = mm[widx];
    end
    if (we) m_wr++; else m_rd++;
    if (e.err) m_err++;
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input bit rst_first);
    exp_t e;
    int   n;
    ia.req_i = 1'b1; ia.we_i = we; ia.addr_i = addr; ia.be_i = be; ia.wdata_i = wd;
    if (rst_first) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_rd = 0; m_wr = 0; m_err = 0;
      chk("rst_wins_busy", ia.busy_o, 0);
    end
    model(we, addr, be, wd, e);
    sb.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!ia.gnt_o && n < 40);
    chk("gnt_latency", n, GA + 1);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin ia.req_i = 1'b0; ia.wdata_i = $urandom; end
    end while (!ia.rvalid_o && n < 40);
    chk("rvalid_latency", n, RA + 1);
    @(negedge clk);
    chk("busy_after_resp", ia.busy_o, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ia.rvalid_o) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%0h, required no pending response", ia.rdata_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rdata", ia.rdata_o, e.rdata);
          chk("err", ia.err_o, e.err);
        end
      end else begin
        chk("idle_rdata_err", {ia.err_o, ia.rdata_o}, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] eg, ev, eb;
    bit         seen;
    int         n;
    exp_t       dummy;
    ia.req_i = 0; ia.we_i = 0; ia.addr_i = 0; ia.be_i = 0; ia.wdata_i = 0;
    ib.req_i = 0; ib.we_i = 0; ib.addr_i = 0; ib.be_i = 0; ib.wdata_i = 0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", ia.gnt_o, 0);
    chk("reset_rvalid", ia.rvalid_o, 0);
    chk("reset_rdata", ia.rdata_o, 0);
    chk("reset_err", ia.err_o, 0);
    chk("reset_busy", ia.busy_o, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 32; i++) txn(1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0);

    // Directed cases: preload, partial-byte write, out-of-range with no aliasing.
    txn(1'b1, 32'h40, 4'hF, 32'hDEADBEEF, 1'b0);
    txn(1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    txn(1'b1, 32'h44, 4'hF, 32'hAABBCCDD, 1'b0);
    txn(1'b1, 32'h44, 4'b0101, 32'h11223344, 1'b0);
    txn(1'b0, 32'h44, 4'h0, 32'h0, 1'b0);
    txn(1'b0, 32'h1000, 4'h0, 32'h0, 1'b0);
    txn(1'b1, 32'h1040, 4'hF, 32'h01234567, 1'b0);
    txn(1'b1, 32'h1000, 4'hF, 32'h89ABCDEF, 1'b0);
    txn(1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    txn(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

    // Request withdrawn during the grant wait.
    ia.req_i = 1'b1; ia.we_i = 1'b1; ia.addr_i = 32'h4C; ia.be_i = 4'hF; ia.wdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    ia.req_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", ia.busy_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); seen = seen | ia.gnt_o | ia.rvalid_o; end
    chk("abort_no_gnt_rvalid", seen, 0);
    txn(1'b0, 32'h4C, 4'h0, 32'h0, 1'b0);

    // Reset while waiting for the response: write stays committed, no rvalid.
    ia.req_i = 1'b1; ia.we_i = 1'b1; ia.addr_i = 32'h48; ia.be_i = 4'hF; ia.wdata_i = 32'hC0FFEE11;
    model(1'b1, 32'h48, 4'hF, 32'hC0FFEE11, dummy);
    n = 0;
    do begin @(negedge clk); n++; end while (!ia.gnt_o && n < 40);
    chk("rstmid_gnt_latency", n, GA + 1);
    @(negedge clk);
    ia.req_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 0;
    chk("rstmid_outputs", {ia.gnt_o, ia.rvalid_o, ia.err_o, ia.busy_o, ia.rdata_o}, 0);
    repeat (8) @(negedge clk);
    txn(1'b0, 32'h48, 4'h0, 32'h0, 1'b0);
    txn(1'b0, 32'h40, 4'h0, 32'h0, 1'b1);

    // Zero-delay instance: back-to-back with req held, one IDLE cycle between.
    eg = 6'b001001; ev = 6'b010010; eb = 6'b011011;
    ib.req_i = 1'b1; ib.we_i = 1'b1; ib.addr_i = 32'h20; ib.be_i = 4'hF; ib.wdata_i = 32'h5A5A0005;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b_gnt", ib.gnt_o, eg[i]);
      chk("b_rvalid", ib.rvalid_o, ev[i]);
      chk("b_busy", ib.busy_o, eb[i]);
      if (i == 1) begin ib.we_i = 1'b0; ib.be_i = 4'h0; ib.wdata_i = 32'h0; end
      if (i == 4) begin
        chk("b_rdata", ib.rdata_o, 32'h5A5A0005);
        ib.req_i = 1'b0;
      end
    end

    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [31:0] addr;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        addr = (32'($urandom_range(1, 1048575)) << 12) | ($urandom & 32'hFFF);
      else
        addr = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      txn(we, addr, 4'($urandom), $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef KUUGA_SC_RESP_STATS_EN
    chk("rd_count_model", a_rd, m_rd);
    chk("wr_count_model", a_wr, m_wr);
    chk("err_count_model", a_er, m_err);
    txn(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    txn(1'b0, 32'h4, 4'h0, 32'h0, 1'b0);
    txn(1'b0, 32'h8, 4'h0, 32'h0, 1'b0);
    txn(1'b1, 32'hC, 4'hF, 32'h1, 1'b0);
    txn(1'b1, 32'h10, 4'hF, 32'h2, 1'b0);
    txn(1'b0, 32'h2000, 4'h0, 32'h0, 1'b0);
    chk("rd_count", a_rd, 4);
    chk("wr_count", a_wr, 2);
    chk("err_count", a_er, 1);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
